// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared ASCON constants, FSM encoding and helpers
//
// Contents:
//   STATE_W / WORD_W  permutation state and word widths
//   fsm_state_t       finalization FSM encoding (IDLE, PERM, FIN)
//   round_const()     12-entry round-constant table, indexed by global round
//   ROT_*             linear-layer rotation amounts per word
//   rotr()            64-bit right rotation
package ascon_pkg;

  localparam int STATE_W = 320;
  localparam int WORD_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PERM = 2'd1,
    FIN  = 2'd2
  } fsm_state_t;

  // Linear-layer rotation pairs, one pair per state word.
  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  // Round constants for p^12; indices past the table return 0 so an idle
  // chain (counter parked at 12) never reads out of range.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational ASCON permutation round
//
// Ports:
//   x0..x4  in   64  state words entering the round
//   rc      in   8   round constant, XORed into the low byte of x2
//   y0..y4  out  64  state words leaving the round
module ascon_round
  import ascon_pkg::*;
(
  input  logic [WORD_W-1:0] x0,
  input  logic [WORD_W-1:0] x1,
  input  logic [WORD_W-1:0] x2,
  input  logic [WORD_W-1:0] x3,
  input  logic [WORD_W-1:0] x4,
  input  logic [7:0]        rc,
  output logic [WORD_W-1:0] y0,
  output logic [WORD_W-1:0] y1,
  output logic [WORD_W-1:0] y2,
  output logic [WORD_W-1:0] y3,
  output logic [WORD_W-1:0] y4
);

  logic [WORD_W-1:0] c2;
  logic [WORD_W-1:0] s0, s1, s2, s3, s4;
  logic [WORD_W-1:0] u0, u1, u2, u3, u4;
  logic [WORD_W-1:0] v0, v1, v2, v3, v4;

  assign c2 = x2 ^ {{(WORD_W-8){1'b0}}, rc};

  // Bit-sliced S-box: input mixing, chi-like core, output mixing.
  // Every stage gets its own names so there is no in-place update.
  assign s0 = x0 ^ x4;
  assign s1 = x1;
  assign s2 = c2 ^ x1;
  assign s3 = x3;
  assign s4 = x4 ^ x3;

  assign u0 = s0 ^ (~s1 & s2);
  assign u1 = s1 ^ (~s2 & s3);
  assign u2 = s2 ^ (~s3 & s4);
  assign u3 = s3 ^ (~s4 & s0);
  assign u4 = s4 ^ (~s0 & s1);

  assign v0 = u0 ^ u4;
  assign v1 = u1 ^ u0;
  assign v2 = ~u2;
  assign v3 = u3 ^ u2;
  assign v4 = u4;

  assign y0 = v0 ^ rotr(v0, ROT_X0_A) ^ rotr(v0, ROT_X0_B);
  assign y1 = v1 ^ rotr(v1, ROT_X1_A) ^ rotr(v1, ROT_X1_B);
  assign y2 = v2 ^ rotr(v2, ROT_X2_A) ^ rotr(v2, ROT_X2_B);
  assign y3 = v3 ^ rotr(v3, ROT_X3_A) ^ rotr(v3, ROT_X3_B);
  assign y4 = v4 ^ rotr(v4, ROT_X4_A) ^ rotr(v4, ROT_X4_B);

endmodule

// File: rtl/finalization.sv
// rtl/finalization.sv - iterative ASCON-128 finalization with tag generate/verify
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               one-cycle request, sampled only in IDLE
//   mode                0 = generate tag, 1 = generate and verify
//   s0..s4              64-bit input state words x0..x4
//   k0, k1              key, k0 = most significant half
//   tag_in0, tag_in1    received tag, tag_in0 = most significant half
//   busy                high from the cycle after acceptance through the done cycle
//   done                one-cycle pulse, tag outputs valid from here on
//   t0, t1              tag words, held until the next result
//   tag_ok              full-width tag match in mode 1, always 0 in mode 0
module finalization
  import ascon_pkg::*;
#(
  parameter int ROUNDS           = 12,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [WORD_W-1:0] s0,
  input  logic [WORD_W-1:0] s1,
  input  logic [WORD_W-1:0] s2,
  input  logic [WORD_W-1:0] s3,
  input  logic [WORD_W-1:0] s4,
  input  logic [WORD_W-1:0] k0,
  input  logic [WORD_W-1:0] k1,
  input  logic [WORD_W-1:0] tag_in0,
  input  logic [WORD_W-1:0] tag_in1,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] t0,
  output logic [WORD_W-1:0] t1,
  output logic              tag_ok
);

  fsm_state_t         state;
  logic [3:0]         cnt;
  logic [STATE_W-1:0] x_q;
  logic [WORD_W-1:0]  k0_q, k1_q, tin0_q, tin1_q;
  logic               mode_q;

  logic [WORD_W-1:0]  r0, r1, r2, r3, r4;

  // Unrolled round chain. Each stage owns its own wires so the chain is a
  // straight feed-forward path; stage j uses constant c[cnt + j].
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_stage
    logic [WORD_W-1:0] a0, a1, a2, a3, a4;
    logic [WORD_W-1:0] y0, y1, y2, y3, y4;
    logic [7:0]        rc;

    if (j == 0) begin : g_first
      assign a0 = x_q[4*WORD_W +: WORD_W];
      assign a1 = x_q[3*WORD_W +: WORD_W];
      assign a2 = x_q[2*WORD_W +: WORD_W];
      assign a3 = x_q[1*WORD_W +: WORD_W];
      assign a4 = x_q[0*WORD_W +: WORD_W];
    end else begin : g_next
      assign a0 = g_stage[j-1].y0;
      assign a1 = g_stage[j-1].y1;
      assign a2 = g_stage[j-1].y2;
      assign a3 = g_stage[j-1].y3;
      assign a4 = g_stage[j-1].y4;
    end

    assign rc = round_const(cnt + 4'(j));

    ascon_round u_round (
      .x0 (a0),
      .x1 (a1),
      .x2 (a2),
      .x3 (a3),
      .x4 (a4),
      .rc (rc),
      .y0 (y0),
      .y1 (y1),
      .y2 (y2),
      .y3 (y3),
      .y4 (y4)
    );
  end

  assign r0 = g_stage[ROUNDS_PER_CYCLE-1].y0;
  assign r1 = g_stage[ROUNDS_PER_CYCLE-1].y1;
  assign r2 = g_stage[ROUNDS_PER_CYCLE-1].y2;
  assign r3 = g_stage[ROUNDS_PER_CYCLE-1].y3;
  assign r4 = g_stage[ROUNDS_PER_CYCLE-1].y4;

  // The tag is registered straight off the final chain output on the last
  // PERM edge, so done and the tag appear together while the FSM sits in FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      t0     <= '0;
      t1     <= '0;
      tag_ok <= 1'b0;
      cnt    <= '0;
      x_q    <= '0;
      k0_q   <= '0;
      k1_q   <= '0;
      tin0_q <= '0;
      tin1_q <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_q    <= {s0, s1 ^ k0, s2 ^ k1, s3, s4};
            k0_q   <= k0;
            k1_q   <= k1;
            tin0_q <= tag_in0;
            tin1_q <= tag_in1;
            mode_q <= mode;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= PERM;
          end
        end
        PERM: begin
          x_q <= {r0, r1, r2, r3, r4};
          cnt <= cnt + 4'(ROUNDS_PER_CYCLE);
          if (int'(cnt) + ROUNDS_PER_CYCLE >= ROUNDS) begin
            t0     <= r3 ^ k0_q;
            t1     <= r4 ^ k1_q;
            tag_ok <= mode_q && ({r3 ^ k0_q, r4 ^ k1_q} == {tin0_q, tin1_q});
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/finalization.md
Name: finalization

Overview:
- Iterative ASCON-128 finalization stage; the counterpart at the output end of the AEAD datapath to the combinational initialization stage.
- Accepts the 320-bit state after the last plaintext/ciphertext block, XORs the key into x1/x2, and runs p^a (12 rounds) with a round counter, at ROUNDS_PER_CYCLE rounds per clock.
- Produces the 128-bit tag T = (x3^k0, x4^k1). In verify mode it also compares T against a received tag.

Parameters:
- ROUNDS, 12: permutation rounds (p^a). Must equal 12 for ASCON-128.
- ROUNDS_PER_CYCLE, 1: unrolled rounds per clock. Legal values are 1, 2, 3, 4, 6 and 12; ROUNDS must be divisible by it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = encrypt (generate tag), 1 = decrypt (generate and verify).
- s0..s4  in  64 each  input state words x0..x4.
- k0, k1  in  64 each  key, k0 = most significant 64 bits.
- tag_in0, tag_in1  in  64 each  received tag for verify, tag_in0 = most significant 64 bits.
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted, inclusive.
- done  out  1  one-cycle pulse; the tag outputs are valid from this cycle on.
- t0, t1  out  64 each  tag words; held until the next accepted start.
- tag_ok  out  1  valid with done. In mode 1 it is 1 iff {t0,t1}=={tag_in0,tag_in1}. Always 0 in mode 0.

Behaviour:
- Reset: synchronous, active-high on clk; the polarity and synchronicity are fixed.
- Reset values: state IDLE, busy=0, done=0, t0=t1=0, tag_ok=0, round counter=0, internal state registers=0.
- A reset mid-operation aborts the permutation and returns to IDLE with all outputs at reset values. No done pulse is produced.

FSM states:
- IDLE: on start=1, latch the following and go to PERM:
  - x0=s0, x1=s1^k0, x2=s2^k1, x3=s3, x4=s4;
  - k0, k1, tag_in0, tag_in1 and mode;
  - counter=0.
  - start=0 keeps the FSM in IDLE.
- PERM: each cycle, apply ROUNDS_PER_CYCLE rounds and add ROUNDS_PER_CYCLE to the counter. When the counter reaches ROUNDS, go to FIN.
- FIN (one cycle):
  - t0=x3^k0_latched, t1=x4^k1_latched;
  - tag_ok computed per mode;
  - done=1;
  - return to IDLE.

Round i (global index 0..11):
- Constant addition: x2 ^= c_i, where c_i = 0xF0 - i*0x0F, giving f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b.
- Substitution: ASCON 5-bit S-box, bit-sliced across the 64 bit columns.
- Linear layer, each word XORed with two right rotations of itself:
  - x0: 19, 28
  - x1: 61, 39
  - x2: 1, 6
  - x3: 10, 17
  - x4: 7, 41

Latency:
- Start accepted at cycle N; done at cycle N + ROUNDS/ROUNDS_PER_CYCLE + 1.
- This is 13 cycles at the defaults.

Boundary conditions:
- Back-to-back: start may be asserted in the cycle done is high. It is ignored there because the FSM is in FIN; it is accepted on the following cycle.
- start while busy is ignored: no queuing and no effect on the running job.
- Input ports may change freely after acceptance, because all operands are latched.
- The tag compare must be full width (128 bits). No early-out.

Decomposition:
- Shared package ascon_pkg:
  - round-constant table (12 x 8 bit);
  - rotation amount constants;
  - FSM state encoding (IDLE, PERM, FIN);
  - STATE_W=320 and WORD_W=64.
- Sub-module ascon_round:
  - combinational single round;
  - inputs: 5 x 64-bit words plus an 8-bit round constant; outputs: 5 x 64-bit words;
  - instantiated ROUNDS_PER_CYCLE times in a chain.
  - The constant for instance j is c[counter+j].
  - The same module is reusable by the existing p12 chain.

Test Plan:
- KAT, encrypt: ASCON-128, key = nonce = 000102..0F, empty AD and PT. Bench derives the finalization input state from the golden model. Expect {t0,t1} = E355159F292911F794CB1432A0103A8A and done at exactly cycle N+13.
- Verify pass and fail: same input with mode=1.
  - tag_in = E355159F292911F794CB1432A0103A8A -> tag_ok=1.
  - Flip bit 0 of tag_in1 -> tag_ok=0, with t0/t1 unchanged.
- Reset mid-permutation: assert rst 5 cycles after start -> busy=0, done is never pulsed, and t0=t1=0 next cycle. A new start then yields the correct KAT tag.
- Start while busy: pulse start with different s0 at cycle N+4 -> ignored; tag equals the first job's tag. Back-to-back start on the done cycle is accepted one cycle later.
- Unroll sweep: ROUNDS_PER_CYCLE = 1, 2, 3, 4, 6, 12 with 100 random states/keys each. Tags match the golden model; latencies are 13, 7, 5, 4, 3, 2 cycles.
- Mode 0 with tag_in equal to the correct tag -> tag_ok=0.
